// File: rtl/jam_cost_table.sv
// jam_cost_table: 8x8 cost matrix for the assignment solver.
// The matrix is loaded row-major over a valid/ready stream. Reads are a pure
// combinational mux. While loading, the block also accumulates the sum of the
// per-row minima, which the solver uses as a lower bound on total cost.
module jam_cost_table #(
    parameter int NW = 8,
    parameter int CW = 7,
    parameter int SW = 10
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   LD_START,
    input  logic                   LD_VALID,
    input  logic [CW-1:0]          LD_DATA,
    output logic                   LD_READY,
    input  logic [$clog2(NW)-1:0]  W,
    input  logic [$clog2(NW)-1:0]  J,
    output logic [CW-1:0]          Cost,
    output logic                   TblReady,
    output logic [SW-1:0]          RowMinSum
);

    localparam int IW = $clog2(NW);
    localparam logic [2*IW-1:0] LAST_IDX = '1;
    localparam logic [IW-1:0]   LAST_COL = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state, state_nxt;
    logic [2*IW-1:0]               idx;
    logic [NW-1:0][NW-1:0][CW-1:0] tbl;
    logic [CW-1:0]                 row_min;
    logic [CW-1:0]                 cur_min;
    logic                          xfer;

    // A restart pulse wins over a same-cycle entry, so that entry is dropped.
    assign xfer    = (state == LOAD) && LD_VALID && !LD_START;
    assign cur_min = (LD_DATA < row_min) ? LD_DATA : row_min;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: any LD_START (re)enters LOAD; the 64th transfer finishes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (LD_START) state_nxt = LOAD;
            LOAD:    if (LD_START) state_nxt = LOAD;
                     else if (xfer && idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (LD_START) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs, decoded from state only so there are no ready bubbles.
    always_comb begin
        LD_READY = 1'b0;
        TblReady = 1'b0;
        case (state)
            LOAD:    LD_READY = 1'b1;
            DONE:    TblReady = 1'b1;
            default: ;
        endcase
    end

    // Load index and running row-minimum / lower-bound accumulation.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx       <= '0;
            row_min   <= '1;
            RowMinSum <= '0;
        end else if (LD_START) begin
            idx       <= '0;
            row_min   <= '1;
            RowMinSum <= '0;
        end else if (xfer) begin
            idx <= idx + 1'b1;
            if (idx[IW-1:0] == LAST_COL) begin
                RowMinSum <= RowMinSum + {{(SW-CW){1'b0}}, cur_min};
                row_min   <= '1;
            end else begin
                row_min   <= cur_min;
            end
        end
    end

    // Matrix storage; entries not yet rewritten keep their old value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)    tbl <= '0;
        else if (xfer) tbl[idx[2*IW-1:IW]][idx[IW-1:0]] <= LD_DATA;
    end

    // Zero-latency lookup; the solver samples this on the same posedge.
    assign Cost = tbl[W][J];

endmodule

// File: tb/tb_jam_cost_table.sv
// Bench for jam_cost_table: directed loads, with a RowMinSum scoreboard that is
// checked whenever TblReady rises, plus direct Cost/handshake checks.
module tb_jam_cost_table;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       LD_START = 1'b0;
    logic       LD_VALID = 1'b0;
    logic [6:0] LD_DATA = '0;
    logic       LD_READY;
    logic [2:0] W = '0;
    logic [2:0] J = '0;
    logic [6:0] Cost;
    logic       TblReady;
    logic [9:0] RowMinSum;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    logic [6:0] vec [64];
    logic [6:0] model [64];
    logic prev_tr = 1'b0;

    jam_cost_table dut (
        .CLK(CLK), .RST_N(RST_N), .LD_START(LD_START), .LD_VALID(LD_VALID),
        .LD_DATA(LD_DATA), .LD_READY(LD_READY), .W(W), .J(J), .Cost(Cost),
        .TblReady(TblReady), .RowMinSum(RowMinSum)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each rising TblReady consumes one expected sum.
    always @(negedge CLK) begin
        if (TblReady && !prev_tr) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 1, 0);
            end else begin
                chk("sb_rowminsum", int'(RowMinSum), exp_q.pop_front());
            end
        end
        prev_tr = TblReady;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                W = 3'(w);
                J = 3'(j);
                #1;
                chk($sformatf("%s_cost_w%0d_j%0d", tag, w, j), int'(Cost),
                    int'(model[w*8+j]));
            end
        end
    endtask

    // Load vec[0..n_stop-1]; a full load (n_stop==64) pushes exp_sum.
    task automatic load(input string tag, input int n_stop, input bit gaps,
                        input int exp_sum);
        int k = 0;
        int cycles = 0;
        int rdy_low = 0;
        bit v;
        bit rdy;
        if (n_stop == 64) exp_q.push_back(exp_sum);
        LD_START = 1'b1;
        LD_VALID = 1'b1;          // must be dropped: LD_START has priority
        LD_DATA  = 7'd99;
        step();
        LD_START = 1'b0;
        while (k < n_stop && cycles < 2000) begin
            v = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            LD_VALID = v;
            LD_DATA  = vec[k];
            #1;
            rdy = LD_READY;
            if (!rdy) rdy_low++;
            if (v && k == 63) chk({tag, "_tblready_before_last"}, int'(TblReady), 0);
            step();
            cycles++;
            if (v && rdy) begin
                model[k] = vec[k];
                k++;
            end
        end
        LD_VALID = 1'b0;
        chk({tag, "_transfers"}, k, n_stop);
        chk({tag, "_ready_low_in_load"}, rdy_low, 0);
        if (!gaps) chk({tag, "_cycles"}, cycles, n_stop);
        if (n_stop == 64) chk({tag, "_tblready_after_last"}, int'(TblReady), 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) model[i] = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tblready", int'(TblReady), 0);
        chk("rst_ld_ready", int'(LD_READY), 0);
        chk("rst_rowminsum", int'(RowMinSum), 0);
        W = 3'd5; J = 3'd2; #1;
        chk("rst_cost", int'(Cost), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        LD_VALID = 1'b1;          // ignored in IDLE
        LD_DATA  = 7'd50;
        step();
        chk("idle_ld_ready", int'(LD_READY), 0);
        LD_VALID = 1'b0;

        // Ascending 8W+J, no gaps: minima 0,8,..,56 -> 224
        for (int i = 0; i < 64; i++) vec[i] = 7'(i);
        load("asc", 64, 1'b0, 224);
        sweep("asc");

        // All 127 -> 8*127 = 1016
        for (int i = 0; i < 64; i++) vec[i] = 7'd127;
        load("max", 64, 1'b0, 1016);
        chk("max_cost_7_7", int'(Cost), 127);

        // Row minimum only at J=7, value W+1 -> 1+..+8 = 36
        for (int i = 0; i < 64; i++) vec[i] = ((i % 8) == 7) ? 7'(i / 8 + 1) : 7'd100;
        load("lastcol", 64, 1'b0, 36);
        sweep("lastcol");

        // Same ascending data with random valid gaps -> 224
        for (int i = 0; i < 64; i++) vec[i] = 7'(i);
        load("gaps", 64, 1'b1, 224);
        sweep("gaps");

        // Abort after 20 entries of 77, then full all-5 load -> 40
        for (int i = 0; i < 64; i++) vec[i] = 7'd77;
        load("abort", 20, 1'b0, 0);
        chk("abort_tblready", int'(TblReady), 0);
        for (int i = 0; i < 64; i++) vec[i] = 7'd5;
        load("five", 64, 1'b0, 40);
        sweep("five");

        // Restart from DONE: TblReady drops, untouched entries keep old data
        for (int i = 0; i < 64; i++) vec[i] = 7'd9;
        load("redo", 10, 1'b0, 0);
        chk("redo_tblready", int'(TblReady), 0);
        chk("redo_rowminsum", int'(RowMinSum), 9);
        W = 3'd0; J = 3'd0; #1;
        chk("redo_cost_0_0", int'(Cost), 9);
        W = 3'd1; J = 3'd1; #1;
        chk("redo_cost_1_1", int'(Cost), 9);
        W = 3'd1; J = 3'd2; #1;
        chk("redo_cost_1_2", int'(Cost), 5);
        W = 3'd7; J = 3'd7; #1;
        chk("redo_cost_7_7", int'(Cost), 5);

        // Asynchronous reset mid-load clears everything
        #2;
        RST_N = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) model[i] = '0;
        chk("arst_tblready", int'(TblReady), 0);
        chk("arst_ld_ready", int'(LD_READY), 0);
        chk("arst_rowminsum", int'(RowMinSum), 0);
        sweep("arst");
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) step();

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream cost source for the 8-worker/8-job assignment solver.
- Loads a 64-entry x 7-bit cost matrix, row-major, over a valid/ready stream.
- Then serves the solver's (W, J) lookups with a same-cycle combinational Cost read.
- Also produces a lower-bound total: the sum of per-worker row minima. The solver can stop early when its MinCost equals this bound.

Parameters:
- NW, 8, workers = jobs = matrix dimension (fixed at 8; index fields are 3 bits).
- CW, 7, cost entry width.
- SW, 10, width of summed costs (8 x 127 = 1016 fits).

Ports:
- CLK  input  1  single clock; all state updates on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- LD_START  input  1  one-cycle pulse; begins or restarts a matrix load.
- LD_VALID  input  1  LD_DATA holds a valid entry.
- LD_DATA  input  CW  cost entry; order is W-major: (0,0),(0,1)..(0,7),(1,0)..(7,7).
- LD_READY  output  1  table accepts an entry this cycle.
- W  input  3  worker index from solver.
- J  input  3  job index from solver.
- Cost  output  CW  table[W][J]; combinational.
- TblReady  output  1  full matrix loaded; Cost and RowMinSum are final.
- RowMinSum  output  SW  sum over W of min over J of table[W][J].

Behaviour:
- Reset (RST_N low, async):
  - state = IDLE; idx = 0; all 64 entries = 0; row_min = 7'h7F.
  - RowMinSum = 0; TblReady = 0; LD_READY = 0.
- States: IDLE, LOAD, DONE (2-bit register).
- LD_READY = 1 only in LOAD; it is a Moore output with no bubbles.
- IDLE:
  - LD_START=1 -> LOAD. On the same edge: idx=0, RowMinSum=0, row_min=7'h7F.
  - LD_VALID is ignored.
- LOAD: a transfer occurs on a posedge with LD_VALID & LD_READY.
  - Transfer writes table[idx[5:3]][idx[2:0]] = LD_DATA, then idx += 1.
  - row_min is updated to min(row_min, LD_DATA).
  - On a transfer with idx[2:0]==7:
    - RowMinSum += min(row_min, LD_DATA), zero-extended to SW bits.
    - row_min resets to 7'h7F.
  - On the transfer with idx==63: same edge -> DONE, TblReady=1, RowMinSum final.
  - idx does not wrap into a new load.
  - LD_VALID low stalls with no state change. Gaps of any length are legal.
- DONE:
  - TblReady held at 1; LD_VALID is ignored.
  - LD_START=1 -> LOAD with the same init as in IDLE. TblReady falls on that edge.
  - Old entries remain readable until overwritten.
- LD_START while in LOAD (mid-load):
  - Abort and restart: idx=0, RowMinSum=0, row_min=7'h7F.
  - Any LD_VALID in that same cycle is not written (LD_START has priority).
- Cost read:
  - Cost = table[W][J] for any W/J at any time. Pure mux, zero latency.
  - The solver changes W/J on negedge and samples Cost on posedge, so no register is allowed in this path.
  - Write and read of the same entry in the same cycle: Cost shows the old value until the write edge, then the new one.
  - Cost is meaningful to the solver only while TblReady=1. The solver is held (not started) until then.
- Arithmetic:
  - Entries are unsigned 0..127.
  - Row min compare is unsigned.
  - RowMinSum never overflows at SW=10.
- Reset mid-load: immediate return to the reset state. Partial contents are cleared.

Test Plan:
- Reset then load entries v = (8*W + J) with LD_VALID tied high.
  -> 64 transfers in 64 cycles; TblReady rises on the edge of transfer 64.
  -> RowMinSum = 0+8+16+..+56 = 224.
  -> Sweep all W/J: Cost = 8*W + J.
- Load all 127 -> RowMinSum = 1016, no overflow.
- Load row W with minimum at J=7 only (row = 100, except J=7 = W+1).
  -> RowMinSum = 36; confirms the last-entry-of-row min path.
- Random LD_VALID gaps (50% duty) on the same data as test 1.
  -> identical table and RowMinSum = 224; LD_READY high throughout LOAD.
- LD_START after 20 transfers, then a full load of all-5.
  -> RowMinSum = 40; TblReady low until transfer 64 of the new load; entries 0..19 are 5, not old data.
- In DONE, assert LD_START.
  -> TblReady drops next edge; Cost still returns old data for untouched entries.
- Pull RST_N low mid-load.
  -> TblReady=0, RowMinSum=0, Cost=0 for all W/J asynchronously.
